alt_pfl_crc_sequencer: RTL

- Upstream control stage for the PFL CRC engine. Sources a byte stream from the flash read path and feeds each byte into an instance of alt_pfl_crc_calculate.
- Then consumes a 2-byte expected-CRC trailer and reads the 16-bit CRC back out through the engine's serial shift port.
- Compares the computed and expected CRCs and reports pass/fail to the configuration controller.

---
 rtl/alt_pfl_crc_pkg.sv | 16 +
 rtl/alt_pfl_crc_calculate.sv | 39 +++
 rtl/alt_pfl_crc_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alt_pfl_crc_pkg.sv
// rtl/alt_pfl_crc_pkg.sv - shared constants and state encoding for the PFL CRC sequencer
package alt_pfl_crc_pkg;

    localparam int CRC_W          = 16;
    localparam int TRAIL_BYTES    = 2;
    localparam int CAPTURE_CYCLES = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DATA    = 3'd1,
        ST_TRAIL   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_t;

endpackage

// File: rtl/alt_pfl_crc_calculate.sv
// rtl/alt_pfl_crc_calculate.sv - byte-wide CRC-16 (poly 0x1021, init 0) with a serial shift port
module alt_pfl_crc_calculate
    import alt_pfl_crc_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       ena,
    input  logic [7:0] d,
    input  logic       shiftenable,
    input  logic       shiftin,
    output logic       shiftout
);

    logic [CRC_W-1:0] r_crc;

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic [7:0] b);
        logic [CRC_W-1:0] v;
        logic             fb;
        v = c;
        for (int i = 7; i >= 0; i--) begin
            fb = v[CRC_W-1] ^ b[i];
            v  = {v[CRC_W-2:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return v;
    endfunction

    // Shifting right, LSB leaves first; shift has priority over a byte update.
    always_ff @(posedge clk) begin
        if (clr)
            r_crc <= '0;
        else if (shiftenable)
            r_crc <= {shiftin, r_crc[CRC_W-1:1]};
        else if (ena)
            r_crc <= crc_step(r_crc, d);
    end

    assign shiftout = r_crc[0];

endmodule

// File: rtl/alt_pfl_crc_sequencer.sv
// rtl/alt_pfl_crc_sequencer.sv - streams payload into the CRC engine, reads it back, compares to trailer
module alt_pfl_crc_sequencer
    import alt_pfl_crc_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      crc_out
);

    seq_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CRC_W-1:0] r_exp;
    logic [CRC_W-1:0] r_cap;
    logic [CRC_W-1:0] r_crc_out;
    logic             r_trail_idx;
    logic [3:0]       r_shcnt;
    logic             r_done;
    logic             r_pass;

    logic             w_start_acc;
    logic             w_accept;
    logic             w_crc_clr;
    logic             w_crc_ena;
    logic             w_shift_en;
    logic             w_shiftout;
    logic [CRC_W-1:0] w_cap_next;

    assign din_ready   = (r_state == ST_DATA) || (r_state == ST_TRAIL);
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign pass        = r_pass;
    assign crc_out     = r_crc_out;

    // abort outranks an accept, so a byte offered alongside abort is dropped.
    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_accept    = din_valid && din_ready && !abort;
    assign w_crc_clr   = clr || w_start_acc;
    assign w_crc_ena   = (r_state == ST_DATA) && w_accept;
    assign w_shift_en  = (r_state == ST_CAPTURE) && !abort;
    assign w_cap_next  = {w_shiftout, r_cap[CRC_W-1:1]};

    alt_pfl_crc_calculate u_crc (
        .clk         (clk),
        .clr         (w_crc_clr),
        .ena         (w_crc_ena),
        .d           (din),
        .shiftenable (w_shift_en),
        .shiftin     (w_shiftout),
        .shiftout    (w_shiftout)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_exp       <= '0;
            r_cap       <= '0;
            r_crc_out   <= '0;
            r_trail_idx <= 1'b0;
            r_shcnt     <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort && r_state != ST_IDLE) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_pass      <= 1'b0;
                            r_crc_out   <= '0;
                            r_exp       <= '0;
                            r_trail_idx <= 1'b0;
                            r_shcnt     <= '0;
                            r_cnt       <= len;
                            r_state     <= (len != '0) ? ST_DATA : ST_TRAIL;
                        end
                    end
                    ST_DATA: begin
                        if (w_accept) begin
                            r_cnt <= r_cnt - 1'b1;
                            if (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1})
                                r_state <= ST_TRAIL;
                        end
                    end
                    ST_TRAIL: begin
                        if (w_accept) begin
                            if (r_trail_idx == 1'(TRAIL_BYTES - 1)) begin
                                r_exp[15:8] <= din;
                                r_shcnt     <= '0;
                                r_state     <= ST_CAPTURE;
                            end else begin
                                r_exp[7:0]  <= din;
                                r_trail_idx <= 1'b1;
                            end
                        end
                    end
                    ST_CAPTURE: begin
                        r_cap   <= w_cap_next;
                        r_shcnt <= r_shcnt + 4'd1;
                        // Results land on the edge entering DONE so they line up with the pulse.
                        if (r_shcnt == 4'(CAPTURE_CYCLES - 1)) begin
                            r_state   <= ST_DONE;
                            r_done    <= 1'b1;
                            r_crc_out <= w_cap_next;
                            r_pass    <= (w_cap_next == r_exp);
                        end
                    end
                    ST_DONE: r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
